apb_timer_multi: RTL
====================

// Module: apb_timer_multi
// PURPOSE
//  NUM_CH independent down-counting timers behind a single APB slave port.
//  Successor to the single 8-bit timer: parametrised width and channel count, one-shot or auto-reload mode.
//  Adds per-channel sticky timeout flags, an interrupt enable per channel, a combined irq, and pslverr.
//  Sits on the APB bus next to the master; timeout/irq lines feed the system controller.
// PARAMETERS
//  NUM_CH    4        number of timer channels (1..16)
//  CNT_W     16       counter/LOAD width; also APB data width (8..32)
//  BASE_ADDR 32'hA000 address of channel 0 register 0
// PORTS
//  pclk       in   1        clock, all logic on posedge
//  preset_n   in   1        reset, synchronous, active-low
//  psel_o     in   1        APB select
//  penable_o  in   1        APB enable (access phase)
//  paddr_o    in   32       APB byte address
//  pwrite_o   in   1        1 = write, 0 = read
//  pwdata_o   in   CNT_W    write data
//  prdata_i   out  CNT_W    read data, valid while pready_i=1
//  pready_i   out  1        transfer complete
//  pslverr_i  out  1        error response, valid while pready_i=1
//  timeout    out  NUM_CH   per-channel sticky expiry flag (level)
//  irq        out  1        OR over channels of (flag & IE)
// BEHAVIOUR
//  Reset (preset_n=0 at posedge): all LOAD/CTRL/COUNT/flags=0, all channels IDLE; pready_i=0, prdata_i=0, pslverr_i=0, timeout=0, irq=0.
//  Address map: addr = BASE_ADDR + 4*ch + r, with ch < NUM_CH and r in 0..3.
//   r0 LOAD (RW)
//   r1 CTRL (RW): bit0 EN, bit1 AUTO, bit2 IE; other bits read 0
//   r2 COUNT (RO)
//   r3 STATUS: bit0 FLAG; write 1 clears, write 0 no effect
//  APB handshake: exactly one wait state per transfer.
//   pready_i <= psel_o & penable_o & ~pready_i.
//   prdata_i and pslverr_i are registered in the same cycle, so they are valid while pready_i=1.
//   A write commits on the posedge where psel_o & penable_o & pready_i.
//   prdata_i holds its last value otherwise.
//  pslverr_i=1 (and the write is dropped; a read returns 0) for:
//   - an address outside the map
//   - a ch >= NUM_CH
//   - a write to COUNT
//  Per-channel FSM: IDLE, RUN, DONE.
//   IDLE/DONE + CTRL write with EN=1 -> COUNT<=LOAD, go to RUN.
//   RUN, COUNT>0 -> COUNT-1 each cycle.
//   RUN, COUNT==0 -> FLAG<=1 (expiry), then:
//    - AUTO=1: COUNT<=LOAD, stay in RUN.
//    - AUTO=0: go to DONE; EN bit cleared in hardware.
//   Any state + CTRL write with EN=0 -> IDLE; COUNT holds its value.
//   CTRL write with EN=1 while already in RUN: AUTO/IE update, COUNT is not reloaded.
//  Timing: expiry is N+1 cycles after the RUN-entry edge (N = LOAD). LOAD=0 expires 1 cycle after entry; with AUTO=1 it expires every cycle.
//  LOAD write while in RUN: takes effect only at the next reload/start.
//  Counter arithmetic is CNT_W bits, unsigned; there is no underflow wrap.
//  Simultaneous W1C and expiry on the same channel: the set wins, FLAG=1.
//  timeout[ch] = FLAG[ch]; it stays high until cleared by W1C or reset.
//  irq is combinational from registered flags and IE bits.
//  Reset asserted mid-count or mid-transfer: everything returns to reset values on that edge. An in-flight APB write is lost.
// TESTING
//  1. Reset: drive preset_n=0 for 2 cycles -> all outputs 0; read CTRL0 after release -> 0, pslverr_i=0.
//  2. One-shot: LOAD0=5, CTRL0=0x5 (EN, IE) -> timeout[0] and irq rise 6 cycles after the commit edge; CTRL0 reads 0x4; COUNT0 reads 0.
//  3. Auto-reload: LOAD1=3, CTRL1=0x3 -> FLAG1 set every 4 cycles; W1C STATUS1 issued on an expiry cycle -> FLAG1 stays 1.
//  4. Stop/resume: stop with EN=0 at COUNT=7 -> COUNT frozen at 7; EN=1 again -> reloads from LOAD, not 7.
//  5. Errors: read BASE+4*NUM_CH -> prdata_i=0, pslverr_i=1; write COUNT0=9 -> pslverr_i=1, COUNT0 unchanged.
//  6. Handshake: every transfer shows pready_i high exactly 1 cycle, one cycle after penable_o rises; no double commit.

Source files
------------

// File: rtl/apb_timer_multi.sv
// NUM_CH independent down-counting timers behind one APB slave port.
// Each channel is one-shot or auto-reload, with a sticky timeout flag and an interrupt enable.
module apb_timer_multi #(
  parameter int unsigned NUM_CH    = 4,
  parameter int unsigned CNT_W     = 16,
  parameter logic [31:0] BASE_ADDR = 32'hA000
) (
  input  logic              pclk,
  input  logic              preset_n,
  input  logic              psel_o,
  input  logic              penable_o,
  input  logic [31:0]       paddr_o,
  input  logic              pwrite_o,
  input  logic [CNT_W-1:0]  pwdata_o,
  output logic [CNT_W-1:0]  prdata_i,
  output logic              pready_i,
  output logic              pslverr_i,
  output logic [NUM_CH-1:0] timeout,
  output logic              irq
);

  localparam int unsigned CH_W      = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam logic [31:0] MAP_BYTES = 32'(4 * NUM_CH);

  typedef enum logic [1:0] {
    REG_LOAD   = 2'd0,
    REG_CTRL   = 2'd1,
    REG_COUNT  = 2'd2,
    REG_STATUS = 2'd3
  } reg_e;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUN,
    ST_DONE
  } ch_state_e;

  // ---------------------------------------------------------------------------
  // Address decode
  // ---------------------------------------------------------------------------
  logic [31:0]     offset;
  logic            in_map;
  logic [CH_W-1:0] sel_ch;
  reg_e            sel_reg;
  logic            addr_err;

  // paddr below BASE_ADDR wraps the subtraction, so the lower bound is checked explicitly.
  assign offset   = paddr_o - BASE_ADDR;
  assign in_map   = (paddr_o >= BASE_ADDR) && (offset < MAP_BYTES);
  assign sel_ch   = offset[2 +: CH_W];
  assign sel_reg  = reg_e'(offset[1:0]);
  assign addr_err = !in_map || (pwrite_o && (sel_reg == REG_COUNT));

  // ---------------------------------------------------------------------------
  // APB handshake: setup cycle raises pready, commit happens while it is high
  // ---------------------------------------------------------------------------
  logic             pready_q, pready_d;
  logic             pslverr_q, pslverr_d;
  logic [CNT_W-1:0] prdata_q, prdata_d;
  logic [CNT_W-1:0] rdata;
  logic             xfer_setup;
  logic             wr_commit;

  assign xfer_setup = psel_o && penable_o && !pready_q;
  assign wr_commit  = psel_o && penable_o && pready_q && pwrite_o && !addr_err;

  // ---------------------------------------------------------------------------
  // Per-channel timers
  // ---------------------------------------------------------------------------
  logic [CNT_W-1:0]  load_arr  [NUM_CH];
  logic [CNT_W-1:0]  count_arr [NUM_CH];
  logic [NUM_CH-1:0] en_vec, auto_vec, ie_vec, flag_vec;

  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    ch_state_e        state_q;
    logic [CNT_W-1:0] load_q, count_q;
    logic             en_q, auto_q, ie_q, flag_q;
    logic             hit, load_wr, ctrl_wr, stat_w1c;
    logic             stop_req, start_req, run_auto, expire;

    assign hit       = wr_commit && (sel_ch == CH_W'(c));
    assign load_wr   = hit && (sel_reg == REG_LOAD);
    assign ctrl_wr   = hit && (sel_reg == REG_CTRL);
    assign stat_w1c  = hit && (sel_reg == REG_STATUS) && pwdata_o[0];
    assign stop_req  = ctrl_wr && !pwdata_o[0];
    assign start_req = ctrl_wr && pwdata_o[0] && (state_q != ST_RUN);
    // A CTRL write landing on the expiry edge already decides reload vs. stop.
    assign run_auto  = ctrl_wr ? pwdata_o[1] : auto_q;
    assign expire    = (state_q == ST_RUN) && (count_q == '0) && !stop_req;

    always_ff @(posedge pclk) begin
      if (!preset_n) begin
        // NOTE: every channel register is reset, not just the FSM state,
        // because software may read LOAD/COUNT/CTRL straight out of reset.
        state_q <= ST_IDLE;
        load_q  <= '0;
        count_q <= '0;
        en_q    <= 1'b0;
        auto_q  <= 1'b0;
        ie_q    <= 1'b0;
        flag_q  <= 1'b0;
      end else begin
        // NOTE: non-blocking assignments throughout, so every branch below
        // sees the pre-edge values of state_q/count_q regardless of order.
        if (load_wr) load_q <= pwdata_o;
        if (ctrl_wr) begin
          auto_q <= pwdata_o[1];
          ie_q   <= pwdata_o[2];
        end

        case (state_q)
          ST_RUN: begin
            if (stop_req) begin
              state_q <= ST_IDLE;
              en_q    <= 1'b0;
            end else if (count_q != '0) begin
              count_q <= count_q - CNT_W'(1);
            end else if (run_auto) begin
              count_q <= load_q;
            end else begin
              state_q <= ST_DONE;
              en_q    <= 1'b0;
            end
          end
          default: begin
            if (start_req) begin
              state_q <= ST_RUN;
              en_q    <= 1'b1;
              count_q <= load_q;
            end else if (stop_req) begin
              state_q <= ST_IDLE;
              en_q    <= 1'b0;
            end
          end
        endcase

        // Expiry beats a simultaneous write-1-to-clear.
        if (expire)        flag_q <= 1'b1;
        else if (stat_w1c) flag_q <= 1'b0;
      end
    end

    assign load_arr[c]  = load_q;
    assign count_arr[c] = count_q;
    assign en_vec[c]    = en_q;
    assign auto_vec[c]  = auto_q;
    assign ie_vec[c]    = ie_q;
    assign flag_vec[c]  = flag_q;
  end

  // ---------------------------------------------------------------------------
  // Read mux and APB response registers
  // ---------------------------------------------------------------------------
  always_comb begin
    // NOTE: default first so no path through the case leaves rdata unassigned
    // (which would otherwise infer a latch).
    rdata = '0;
    if (in_map) begin
      case (sel_reg)
        REG_LOAD:   rdata = load_arr[sel_ch];
        REG_CTRL:   rdata = CNT_W'({ie_vec[sel_ch], auto_vec[sel_ch], en_vec[sel_ch]});
        REG_COUNT:  rdata = count_arr[sel_ch];
        REG_STATUS: rdata = CNT_W'(flag_vec[sel_ch]);
        default:    rdata = '0;
      endcase
    end
  end

  always_comb begin
    pready_d  = xfer_setup;
    pslverr_d = xfer_setup && addr_err;
    prdata_d  = prdata_q;
    if (xfer_setup && !pwrite_o) prdata_d = addr_err ? '0 : rdata;
  end

  always_ff @(posedge pclk) begin
    if (!preset_n) begin
      pready_q  <= 1'b0;
      pslverr_q <= 1'b0;
      prdata_q  <= '0;
    end else begin
      pready_q  <= pready_d;
      pslverr_q <= pslverr_d;
      prdata_q  <= prdata_d;
    end
  end

  assign pready_i  = pready_q;
  assign pslverr_i = pslverr_q;
  assign prdata_i  = prdata_q;
  assign timeout   = flag_vec;
  assign irq       = |(flag_vec & ie_vec);

endmodule
